// File: rtl/shifter_pkg.sv
// Shared op-code enum and decode helpers for the pipelined shifter.
// Rotate support is compiled in only when SHIFTER_ROTATE_EN is defined.
package shifter_pkg;

    typedef enum logic [2:0] {
        SH_SRL = 3'b000,
        SH_SRA = 3'b001,
        SH_SLL = 3'b010,
        SH_SLA = 3'b011,
        SH_ROR = 3'b100,
        SH_ROL = 3'b101
    } shop_e;

    // Left ops run through the right-shift datapath on bit-reversed operands.
    function automatic logic is_left(shop_e op);
        return (op == SH_SLL) || (op == SH_SLA) || (op == SH_ROL);
    endfunction

    function automatic logic is_legal(shop_e op);
`ifdef SHIFTER_ROTATE_EN
        return (op[2] == 1'b0) || (op == SH_ROR) || (op == SH_ROL);
`else
        return op[2] == 1'b0;
`endif
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline stage: LAYERS right-shift/rotate mux layers, then the valid/data/op/amt register.
// Rotate wrap-around exists only when SHIFTER_ROTATE_EN is defined.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SHW    = 5,
    parameter int unsigned LAYERS = 1,
    parameter int unsigned BASE   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    input  shop_e            i_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [SHW-1:0]   o_amt,
    output shop_e            o_op
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    shop_e            op_q;
    logic             fill;
    logic [WIDTH-1:0] layer [LAYERS+1];

    // SRA keeps the sign in the MSB through every layer, so it can be re-read here.
    assign fill     = (i_op == SH_SRA) && i_data[WIDTH-1];
    assign layer[0] = i_data;

`ifdef SHIFTER_ROTATE_EN
    logic rot;
    assign rot = (i_op == SH_ROR) || (i_op == SH_ROL);
`endif

    for (genvar j = 0; j < LAYERS; j++) begin : g_layer
        localparam int unsigned SH = 1 << (BASE + j);
        logic [SH-1:0] wrap;
`ifdef SHIFTER_ROTATE_EN
        assign wrap = rot ? layer[j][SH-1:0] : {SH{fill}};
`else
        assign wrap = {SH{fill}};
`endif
        assign layer[j+1] = i_amt[j] ? {wrap, layer[j][WIDTH-1:SH]} : layer[j];
    end

    assign o_ready = !valid_q || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            op_q    <= SH_SRL;
        end else if (o_ready) begin
            valid_q <= i_valid;
            data_q  <= layer[LAYERS];
            amt_q   <= i_amt >> LAYERS;
            op_q    <= i_op;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_amt   = amt_q;
    assign o_op    = op_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shift/rotate unit with valid/ready handshake; REG_EVERY mux layers per stage.
// Define SHIFTER_ROTATE_EN to enable ROR/ROL.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_EVERY = 1,
    localparam int unsigned SHW      = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    input  logic [2:0]       i_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_illegal
);

    localparam int unsigned LAT = (SHW + REG_EVERY - 1) / REG_EVERY;

    logic [LAT:0]     vld;
    logic [LAT:0]     rdy;
    logic [WIDTH-1:0] data [LAT+1];
    logic [SHW-1:0]   amt  [LAT+1];
    shop_e            op   [LAT+1];

    shop_e            in_op;
    shop_e            out_op;
    logic [WIDTH-1:0] in_rev;
    logic [WIDTH-1:0] out_rev;
    logic [WIDTH-1:0] result;

    assign in_op = shop_e'(i_op);

    for (genvar b = 0; b < WIDTH; b++) begin : g_rev
        assign in_rev[b]  = i_data[WIDTH-1-b];
        assign out_rev[b] = data[LAT][WIDTH-1-b];
    end

    assign vld[0]   = i_valid;
    assign data[0]  = is_left(in_op) ? in_rev : i_data;
    assign amt[0]   = i_amt;
    assign op[0]    = in_op;
    assign rdy[LAT] = i_ready;
    assign o_ready  = rdy[0];

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int unsigned BASE   = k * REG_EVERY;
        // The last stage takes whatever layers remain when SHW is not a multiple of REG_EVERY.
        localparam int unsigned LAYERS = (SHW - BASE < REG_EVERY) ? (SHW - BASE) : REG_EVERY;

        shifter_stage #(
            .WIDTH  (WIDTH),
            .SHW    (SHW),
            .LAYERS (LAYERS),
            .BASE   (BASE)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_valid (vld[k]),
            .o_ready (rdy[k]),
            .i_data  (data[k]),
            .i_amt   (amt[k]),
            .i_op    (op[k]),
            .o_valid (vld[k+1]),
            .i_ready (rdy[k+1]),
            .o_data  (data[k+1]),
            .o_amt   (amt[k+1]),
            .o_op    (op[k+1])
        );
    end

    assign out_op    = op[LAT];
    assign result    = is_left(out_op) ? out_rev : data[LAT];
    assign o_valid   = vld[LAT];
    assign o_data    = (o_valid && is_legal(out_op)) ? result : '0;
    assign o_illegal = o_valid && !is_legal(out_op);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed corners plus a scoreboarded random stream.
// Expectations follow SHIFTER_ROTATE_EN the same way the design build does.
module tb_pipelined_barrel_shifter;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned REG_EVERY = 1;
    localparam int unsigned SHW       = $clog2(WIDTH);
    localparam int unsigned LAT       = (SHW + REG_EVERY - 1) / REG_EVERY;
    localparam int unsigned TOTAL     = 8 * 1500;

    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] A5   = {(WIDTH/8){8'hA5}};
    localparam logic [WIDTH:0]   ILL  = {1'b1, {WIDTH{1'b0}}};
`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   a;
        logic [2:0]       op;
        logic [WIDTH:0]   e;
    } vec_t;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic [SHW-1:0]   i_amt;
    logic [2:0]       i_op;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_illegal;

    logic [WIDTH:0] sb [$];
    int vectors = 0;
    int miscompares = 0;

    pipelined_barrel_shifter #(
        .WIDTH     (WIDTH),
        .REG_EVERY (REG_EVERY)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_amt     (i_amt),
        .i_op      (i_op),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_illegal (o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Golden model built on the language shift operators: {illegal, data}.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                                             input logic [2:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:       r = d >> a;
            3'd1:       r = $signed(d) >>> a;
            3'd2, 3'd3: r = d << a;
`ifdef SHIFTER_ROTATE_EN
            3'd4:       r = (d >> a) | (d << (WIDTH - a));
            3'd5:       r = (d << a) | (d >> (WIDTH - a));
`endif
            default:    return ILL;
        endcase
        return {1'b0, r};
    endfunction

    task automatic next_cycle;
        @(posedge i_clk);
        #1;
    endtask

    // Sample mid-cycle: transfers flagged here happen on the coming rising edge.
    task automatic step(output bit in_x, output bit out_x);
        @(negedge i_clk);
        in_x  = i_valid && o_ready;
        out_x = o_valid && i_ready;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;
        i_amt   = '0;
        i_op    = 3'd0;
        repeat (2) @(posedge i_clk);
        #1;
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_o_valid: got %b want 0", o_valid);
        end
        vectors++;
        if (o_data !== '0 || o_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h ill=%b want 0/0", o_data, o_illegal);
        end
        vectors++;
        if (o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_o_ready: got %b want 1", o_ready);
        end
        i_rst_n = 1'b1;
        next_cycle;
    endtask

    task automatic test_latency;
        int cyc;
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = MSB;
        i_amt   = SHW'(4);
        i_op    = 3'd0;
        next_cycle;
        i_valid = 1'b0;
        cyc = 1;
        while (o_valid !== 1'b1 && cyc < 4 * LAT) begin
            next_cycle;
            cyc++;
        end
        vectors++;
        if (cyc != LAT) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles want %0d", cyc, LAT);
        end
        vectors++;
        if (o_data !== (MSB >> 4) || o_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_data: got %h ill=%b want %h", o_data, o_illegal, MSB >> 4);
        end
        next_cycle;
        vectors++;
        if (o_valid !== 1'b0 || o_data !== '0) begin
            miscompares++;
            $display("FAIL latency_single: got valid=%b data=%h want 0/0", o_valid, o_data);
        end
    endtask

    task automatic test_corners;
        vec_t v [$];
        logic [SHW-1:0] amax;
        logic [WIDTH:0] exp;
        int sent, got, cyc;
        bit in_x, out_x;
        amax = '1;
        v.push_back('{MSB, amax, 3'd1, {1'b0, ALL}});
        v.push_back('{MSB, amax, 3'd0, {1'b0, ONE}});
        v.push_back('{ONE, amax, 3'd2, {1'b0, MSB}});
        v.push_back('{ONE, amax, 3'd3, {1'b0, MSB}});
        v.push_back('{ALL, amax, 3'd2, {1'b0, MSB}});
        v.push_back('{MSB, SHW'(1), 3'd1, {3'b011, {(WIDTH-2){1'b0}}}});
        v.push_back('{MSB >> 1, SHW'(1), 3'd1, {1'b0, MSB >> 2}});
        for (int op = 0; op < 8; op++) begin
            v.push_back('{A5, '0, 3'(op), (op < 4 || (ROT && op < 6)) ? {1'b0, A5} : ILL});
        end
        sent = 0;
        got = 0;
        cyc = 0;
        i_ready = 1'b1;
        while (got < v.size() && cyc < 200) begin
            i_valid = (sent < v.size());
            if (sent < v.size()) begin
                i_data = v[sent].d;
                i_amt  = v[sent].a;
                i_op   = v[sent].op;
            end
            step(in_x, out_x);
            if (out_x) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL corner_extra: got %h want no output", o_data);
                end else begin
                    exp = sb.pop_front();
                    if ({o_illegal, o_data} !== exp) begin
                        miscompares++;
                        $display("FAIL corner[%0d]: got ill=%b data=%h want ill=%b data=%h",
                                 got, o_illegal, o_data, exp[WIDTH], exp[WIDTH-1:0]);
                    end
                end
                got++;
            end
            if (in_x) begin
                sb.push_back(v[sent].e);
                sent++;
            end
            next_cycle;
            cyc++;
        end
        i_valid = 1'b0;
        vectors++;
        if (got != v.size()) begin
            miscompares++;
            $display("FAIL corner_timeout: got %0d results want %0d", got, v.size());
        end
    endtask

    task automatic test_rotate;
        vec_t v [$];
        logic [WIDTH:0] exp;
        int sent, got, cyc;
        bit in_x, out_x;
        v.push_back('{ONE, SHW'(1), 3'd4, ROT ? {1'b0, MSB} : ILL});
        v.push_back('{MSB, SHW'(1), 3'd5, ROT ? {1'b0, ONE} : ILL});
        v.push_back('{ONE | (ONE << 1), SHW'(1), 3'd4, ROT ? {1'b0, MSB | ONE} : ILL});
        v.push_back('{ONE, SHW'(3), 3'd6, ILL});
        v.push_back('{ALL, SHW'(2), 3'd7, ILL});
        sent = 0;
        got = 0;
        cyc = 0;
        i_ready = 1'b1;
        while (got < v.size() && cyc < 200) begin
            i_valid = (sent < v.size());
            if (sent < v.size()) begin
                i_data = v[sent].d;
                i_amt  = v[sent].a;
                i_op   = v[sent].op;
            end
            step(in_x, out_x);
            if (out_x) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rotate_extra: got %h want no output", o_data);
                end else begin
                    exp = sb.pop_front();
                    if ({o_illegal, o_data} !== exp) begin
                        miscompares++;
                        $display("FAIL rotate[%0d]: got ill=%b data=%h want ill=%b data=%h",
                                 got, o_illegal, o_data, exp[WIDTH], exp[WIDTH-1:0]);
                    end
                end
                got++;
            end
            if (in_x) begin
                sb.push_back(v[sent].e);
                sent++;
            end
            next_cycle;
            cyc++;
        end
        i_valid = 1'b0;
        vectors++;
        if (got != v.size()) begin
            miscompares++;
            $display("FAIL rotate_timeout: got %0d results want %0d", got, v.size());
        end
    endtask

    task automatic test_back_pressure;
        logic [WIDTH-1:0] d [8];
        logic [WIDTH:0] first, exp;
        logic [63:0] r;
        int sent;
        bit in_x, out_x;
        for (int k = 0; k < 8; k++) begin
            r = {$urandom, $urandom};
            d[k] = r[WIDTH-1:0];
        end
        first = model(d[0], SHW'(1), 3'd0);
        sent = 0;
        i_ready = 1'b0;
        repeat (LAT + 3) begin
            i_valid = (sent < 8);
            i_data  = d[sent % 8];
            i_amt   = SHW'(sent + 1);
            i_op    = 3'(sent % 4);
            step(in_x, out_x);
            if (in_x) begin
                sb.push_back(model(i_data, i_amt, i_op));
                sent++;
            end
            if (o_valid) begin
                vectors++;
                if ({o_illegal, o_data} !== first) begin
                    miscompares++;
                    $display("FAIL bp_hold: got %h want %h", o_data, first[WIDTH-1:0]);
                end
            end
            next_cycle;
        end
        vectors++;
        if (sent != LAT) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d accepts want %0d", sent, LAT);
        end
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_o_ready: got %b want 0", o_ready);
        end
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            i_valid = (sent < 8);
            i_data  = d[sent % 8];
            i_amt   = SHW'(sent + 1);
            i_op    = 3'(sent % 4);
            step(in_x, out_x);
            vectors++;
            if (!out_x || sb.size() == 0) begin
                miscompares++;
                $display("FAIL bp_bubble: cycle %0d got valid=%b want 1", c, o_valid);
            end else begin
                exp = sb.pop_front();
                if ({o_illegal, o_data} !== exp) begin
                    miscompares++;
                    $display("FAIL bp_order[%0d]: got %h want %h", c, o_data, exp[WIDTH-1:0]);
                end
            end
            if (in_x) begin
                sb.push_back(model(i_data, i_amt, i_op));
                sent++;
            end
            next_cycle;
        end
        i_valid = 1'b0;
        vectors++;
        if (sent != 8 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL bp_drain: got sent=%0d left=%0d want 8/0", sent, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_flight;
        bit in_x, out_x;
        int acc;
        acc = 0;
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = A5 >> k;
            i_amt   = SHW'(k);
            i_op    = 3'd0;
            step(in_x, out_x);
            if (in_x) acc++;
            next_cycle;
        end
        i_valid = 1'b0;
        vectors++;
        if (acc != 3) begin
            miscompares++;
            $display("FAIL rmf_accepts: got %0d want 3", acc);
        end
        i_rst_n = 1'b0;
        next_cycle;
        i_rst_n = 1'b1;
        vectors++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmf_release: got valid=%b ready=%b want 0/1", o_valid, o_ready);
        end
        i_ready = 1'b1;
        for (int c = 0; c < 2 * LAT + 2; c++) begin
            next_cycle;
            vectors++;
            if (o_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rmf_ghost: cycle %0d got valid=%b data=%h want 0", c, o_valid, o_data);
            end
        end
    endtask

    task automatic test_random;
        logic [WIDTH:0] exp;
        logic [63:0] r;
        int unsigned t;
        int sent, got, cyc;
        bit in_x, out_x;
        sent = 0;
        got = 0;
        cyc = 0;
        while ((sent < TOTAL || got < sent) && cyc < 60000) begin
            r       = {$urandom, $urandom};
            t       = $urandom_range(0, WIDTH - 1);
            i_data  = r[WIDTH-1:0];
            i_amt   = t[SHW-1:0];
            i_op    = 3'($urandom_range(0, 7));
            i_valid = (sent < TOTAL) && ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            step(in_x, out_x);
            if (out_x) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra: got %h want no output", o_data);
                end else begin
                    exp = sb.pop_front();
                    if ({o_illegal, o_data} !== exp) begin
                        miscompares++;
                        $display("FAIL rand[%0d]: got ill=%b data=%h want ill=%b data=%h",
                                 got, o_illegal, o_data, exp[WIDTH], exp[WIDTH-1:0]);
                    end
                end
                got++;
            end
            if (!o_valid) begin
                vectors++;
                if (o_data !== '0 || o_illegal !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_idle: got data=%h ill=%b want 0/0", o_data, o_illegal);
                end
            end
            if (in_x) begin
                sb.push_back(model(i_data, i_amt, i_op));
                sent++;
            end
            next_cycle;
            cyc++;
        end
        i_valid = 1'b0;
        vectors++;
        if (sent != TOTAL || got != TOTAL) begin
            miscompares++;
            $display("FAIL rand_timeout: got sent=%0d done=%0d want %0d", sent, got, TOTAL);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_rotate();
        test_back_pressure();
        test_reset_mid_flight();
        sb.delete();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
